// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory self-test engine.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        WAIT = 3'd3,
        CHK  = 3'd4,
        DONE = 3'd5
    } bist_state_e;

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        DATA_ADDR = 2'd1,
        CHECKER   = 2'd2,
        ALL       = 2'd3
    } bist_mode_e;

    // Two-bit tiles replicated across the data word: 0x55 on even addresses, 0xAA on odd.
    localparam logic [1:0] CB_EVEN_PAIR = 2'b01;
    localparam logic [1:0] CB_ODD_PAIR  = 2'b10;

endpackage

// File: rtl/mem_bist_pattern.sv
// Combinational test-pattern generator p(a); one copy feeds both write data and compare.
module mem_bist_pattern
    import mem_bist_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  bist_mode_e          i_pat,
    input  logic [AWIDTH-1:0]   i_addr,
    output logic [DWIDTH-1:0]   o_data
);

    localparam int NPAIR = (DWIDTH + 1) / 2;

    logic [DWIDTH-1:0] w_addr_data;
    logic [DWIDTH-1:0] w_cb_even;
    logic [DWIDTH-1:0] w_cb_odd;

    // Size casts zero-extend or truncate, so any AWIDTH/DWIDTH pairing works.
    assign w_addr_data = DWIDTH'(i_addr);
    assign w_cb_even   = DWIDTH'({NPAIR{CB_EVEN_PAIR}});
    assign w_cb_odd    = DWIDTH'({NPAIR{CB_ODD_PAIR}});

    always_comb begin
        o_data = '0;
        case (i_pat)
            CLEAR:     o_data = '0;
            DATA_ADDR: o_data = w_addr_data;
            CHECKER:   o_data = i_addr[0] ? w_cb_odd : w_cb_even;
            default:   o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_bist_engine.sv
// Memory self-test engine: write-then-read-back passes with error count and first-failure capture.
module mem_bist_engine
    import mem_bist_pkg::*;
#(
    parameter int AWIDTH   = 5,
    parameter int DWIDTH   = 8,
    parameter int READ_LAT = 1,
    parameter int ECNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              abort,
    output logic [AWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] data_in,
    output logic              write,
    output logic              read,
    input  logic [DWIDTH-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              aborted,
    output logic [ECNT_W-1:0] err_count,
    output logic [AWIDTH-1:0] first_err_addr,
    output logic [DWIDTH-1:0] first_err_data
);

    localparam int                LAT_W     = $clog2(READ_LAT) + 1;
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((READ_LAT >= 2) ? (READ_LAT - 2) : 0);
    localparam logic [AWIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ECNT_W-1:0] ECNT_MAX  = '1;

    bist_state_e       r_state;
    bist_mode_e        r_mode;
    bist_mode_e        r_pat;
    logic [AWIDTH-1:0] r_addr;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic              r_done;
    logic              r_aborted;
    logic [ECNT_W-1:0] r_err_count;
    logic [AWIDTH-1:0] r_first_err_addr;
    logic [DWIDTH-1:0] r_first_err_data;

    bist_mode_e        w_start_mode;
    logic [DWIDTH-1:0] w_pat_data;
    logic              w_busy;
    logic              w_mismatch;
    logic              w_last_pat;

    mem_bist_pattern #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_pattern (
        .i_pat  (r_pat),
        .i_addr (r_addr),
        .o_data (w_pat_data)
    );

    assign w_start_mode = bist_mode_e'(mode);
    assign w_busy       = (r_state == WR) || (r_state == RD) ||
                          (r_state == WAIT) || (r_state == CHK);
    // 4-state compare so X/Z on the memory bus counts as a failure.
    assign w_mismatch   = (data_out !== w_pat_data);
    assign w_last_pat   = (r_mode != ALL) || (r_pat == CHECKER);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_mode           <= CLEAR;
            r_pat            <= CLEAR;
            r_addr           <= '0;
            r_lat_cnt        <= '0;
            r_done           <= 1'b0;
            r_aborted        <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_first_err_data <= '0;
        end else if (!w_busy) begin
            if (start) begin
                r_mode           <= w_start_mode;
                r_pat            <= (w_start_mode == ALL) ? CLEAR : w_start_mode;
                r_addr           <= '0;
                r_lat_cnt        <= '0;
                r_done           <= 1'b0;
                r_aborted        <= 1'b0;
                r_err_count      <= '0;
                r_first_err_addr <= '0;
                r_first_err_data <= '0;
                r_state          <= WR;
            end else if (r_state == DONE) begin
                r_state <= IDLE;
            end
        end else if (abort) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
        end else begin
            case (r_state)
                WR: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_addr == ADDR_LAST) r_state <= RD;
                end
                RD: begin
                    r_lat_cnt <= '0;
                    r_state   <= (READ_LAT == 1) ? CHK : WAIT;
                end
                WAIT: begin
                    if (r_lat_cnt == LAT_LAST) r_state <= CHK;
                    else                       r_lat_cnt <= r_lat_cnt + 1'b1;
                end
                CHK: begin
                    if (w_mismatch) begin
                        if (r_err_count != ECNT_MAX) r_err_count <= r_err_count + 1'b1;
                        if (r_err_count == '0) begin
                            r_first_err_addr <= r_addr;
                            r_first_err_data <= data_out;
                        end
                    end
                    r_addr <= r_addr + 1'b1;
                    if (r_addr != ADDR_LAST) begin
                        r_state <= RD;
                    end else if (w_last_pat) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_pat   <= (r_pat == CLEAR) ? DATA_ADDR : CHECKER;
                        r_state <= WR;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign addr           = r_addr;
    assign data_in        = w_pat_data;
    assign write          = (r_state == WR);
    assign read           = (r_state == RD);
    assign busy           = w_busy;
    assign done           = r_done;
    assign pass           = r_done && !r_aborted && (r_err_count == '0);
    assign aborted        = r_aborted;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;
    assign first_err_data = r_first_err_data;

endmodule

// File: tb/tb_mem_bist_engine.sv
// Self-checking bench for mem_bist_engine with behavioural memories at READ_LAT 1 and 3.
module tb_mem_bist_engine;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start1 = 1'b0, abort1 = 1'b0;
    logic [1:0]  mode1 = 2'd0;
    logic        start3 = 1'b0, abort3 = 1'b0;
    logic [1:0]  mode3 = 2'd0;

    logic [4:0]  addr1, fea1, addr3, fea3;
    logic [7:0]  din1, dout1, fed1, din3, dout3, fed3;
    logic        write1, read1, busy1, done1, pass1, abt1;
    logic        write3, read3, busy3, done3, pass3, abt3;
    logic [15:0] ecnt1, ecnt3;

    mem_bist_engine #(.AWIDTH(5), .DWIDTH(8), .READ_LAT(1), .ECNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .start(start1), .mode(mode1), .abort(abort1),
        .addr(addr1), .data_in(din1), .write(write1), .read(read1), .data_out(dout1),
        .busy(busy1), .done(done1), .pass(pass1), .aborted(abt1), .err_count(ecnt1),
        .first_err_addr(fea1), .first_err_data(fed1)
    );

    mem_bist_engine #(.AWIDTH(5), .DWIDTH(8), .READ_LAT(3), .ECNT_W(16)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .mode(mode3), .abort(abort3),
        .addr(addr3), .data_in(din3), .write(write3), .read(read3), .data_out(dout3),
        .busy(busy3), .done(done3), .pass(pass3), .aborted(abt3), .err_count(ecnt3),
        .first_err_addr(fea3), .first_err_data(fed3)
    );

    // Behavioural memories; fault_en corrupts two reads of the latency-1 memory.
    logic [7:0] mem1 [32];
    logic [7:0] mem3 [32];
    logic [7:0] rdq3 [3];
    logic       fault_en = 1'b0;

    always @(posedge clk) begin
        if (write1) mem1[addr1] <= din1;
        if (read1) begin
            if (fault_en && addr1 == 5'd5)      dout1 <= 8'h04;
            else if (fault_en && addr1 == 5'd9) dout1 <= 8'h00;
            else                                dout1 <= mem1[addr1];
        end
        if (write3) mem3[addr3] <= din3;
        rdq3[0] <= mem3[addr3];
        rdq3[1] <= rdq3[0];
        rdq3[2] <= rdq3[1];
    end
    assign dout3 = rdq3[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int p, input int a);
        logic [7:0] v;
        case (p)
            0:       v = 8'h00;
            1:       v = 8'(a);
            default: v = (a % 2 == 1) ? 8'hAA : 8'h55;
        endcase
        return v;
    endfunction

    // Scoreboard queues for the latency-1 DUT.
    wr_t        wq[$];
    logic [4:0] rq[$];
    int busy_cyc1 = 0;
    int busy_cyc3 = 0, wr_cnt3 = 0, rd_cnt3 = 0;

    task automatic push_pattern(input int p);
        wr_t e;
        for (int a = 0; a < 32; a++) begin
            e.a = 5'(a);
            e.d = pat(p, a);
            wq.push_back(e);
        end
        for (int a = 0; a < 32; a++) rq.push_back(5'(a));
    endtask

    always @(negedge clk) begin
        wr_t e;
        logic [4:0] ra;
        if (busy1) busy_cyc1++;
        if (busy3) busy_cyc3++;
        if (write3) wr_cnt3++;
        if (read3) rd_cnt3++;
        if (write1 && read1) chk("wr_rd_excl", 32'(write1 & read1), 32'd0);
        if (write1) begin
            if (wq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else begin
                e = wq.pop_front();
                chk("wr_addr", 32'(addr1), 32'(e.a));
                chk("wr_data", 32'(din1), 32'(e.d));
            end
        end
        if (read1) begin
            if (rq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else begin
                ra = rq.pop_front();
                chk("rd_addr", 32'(addr1), 32'(ra));
            end
        end
    end

    task automatic pulse_start1(input logic [1:0] m);
        @(negedge clk);
        mode1  = m;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_done1(input int maxc);
        int n;
        n = 0;
        while (!done1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!done1) chk("done1_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_addr"}, 32'(addr1), 32'd0);
        chk({tag, "_data_in"}, 32'(din1), 32'd0);
        chk({tag, "_strobes"}, 32'({write1, read1}), 32'd0);
        chk({tag, "_flags"}, 32'({busy1, done1, pass1, abt1}), 32'd0);
        chk({tag, "_err"}, 32'({ecnt1, fea1, fed1}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        chk("reset3_flags", 32'({busy3, done3, write3, read3}), 32'd0);
        reset = 1'b0;

        // Clear pass: 96 busy cycles, then one DONE cycle and sticky results.
        busy_cyc1 = 0;
        push_pattern(0);
        pulse_start1(2'd0);
        chk("s1_busy_next", 32'(busy1), 32'd1);
        wait_done1(200);
        chk("s1_done_cycle_busy", 32'(busy1), 32'd0);
        chk("s1_pass", 32'({done1, pass1, abt1}), 32'b110);
        chk("s1_err", 32'(ecnt1), 32'd0);
        chk("s1_busy_cycles", 32'(busy_cyc1), 32'd96);
        @(negedge clk);
        chk("s1_sticky", 32'({busy1, done1, pass1}), 32'b011);
        chk("s1_q_empty", 32'(wq.size() + rq.size()), 32'd0);

        // data=address pass.
        busy_cyc1 = 0;
        push_pattern(1);
        pulse_start1(2'd1);
        chk("s2_done_cleared", 32'(done1), 32'd0);
        wait_done1(200);
        chk("s2_mem7", 32'(mem1[7]), 32'h07);
        chk("s2_mem31", 32'(mem1[31]), 32'h1F);
        chk("s2_pass", 32'({done1, pass1, abt1}), 32'b110);
        chk("s2_busy_cycles", 32'(busy_cyc1), 32'd96);

        // Two corrupted reads.
        fault_en = 1'b1;
        push_pattern(1);
        pulse_start1(2'd1);
        wait_done1(200);
        chk("s3_err_count", 32'(ecnt1), 32'd2);
        chk("s3_first_addr", 32'(fea1), 32'd5);
        chk("s3_first_data", 32'(fed1), 32'h04);
        chk("s3_pass", 32'({done1, pass1, abt1}), 32'b100);
        fault_en = 1'b0;
        @(negedge clk);

        // All three patterns back to back.
        busy_cyc1 = 0;
        push_pattern(0);
        push_pattern(1);
        push_pattern(2);
        pulse_start1(2'd3);
        wait_done1(600);
        chk("s4_busy_cycles", 32'(busy_cyc1), 32'd288);
        chk("s4_mem2", 32'(mem1[2]), 32'h55);
        chk("s4_mem3", 32'(mem1[3]), 32'hAA);
        chk("s4_pass", 32'({done1, pass1, abt1}), 32'b110);
        chk("s4_q_empty", 32'(wq.size() + rq.size()), 32'd0);

        // Abort during the 10th write cycle.
        push_pattern(1);
        pulse_start1(2'd1);
        repeat (9) @(negedge clk);
        chk("s5_pre_abort_addr", 32'(addr1), 32'd9);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("s5_strobes_low", 32'({write1, read1}), 32'd0);
        chk("s5_flags", 32'({busy1, done1, abt1, pass1}), 32'b0110);
        chk("s5_err_kept", 32'(ecnt1), 32'd0);
        chk("s5_q_left", 32'(wq.size()), 32'd22);
        wq.delete();
        rq.delete();
        @(negedge clk);
        // Start and abort together while idle: start wins.
        busy_cyc1 = 0;
        push_pattern(2);
        mode1  = 2'd2;
        start1 = 1'b1;
        abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        chk("s5_restart_flags", 32'({busy1, done1, abt1}), 32'b100);
        wait_done1(200);
        chk("s5_restart_pass", 32'({done1, pass1, abt1}), 32'b110);
        chk("s5_restart_cycles", 32'(busy_cyc1), 32'd96);

        // Reset in the middle of the read phase.
        push_pattern(1);
        pulse_start1(2'd1);
        begin
            int n;
            n = 0;
            while (!(read1 && addr1 == 5'd3) && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("s6_reached_read3", 32'(read1 && addr1 == 5'd3), 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        chk_idle_zero("s6_reset");
        reset = 1'b0;
        wq.delete();
        rq.delete();

        // A start pulse mid-run must not restart the test.
        busy_cyc1 = 0;
        push_pattern(1);
        pulse_start1(2'd1);
        repeat (4) @(negedge clk);
        mode1  = 2'd2;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1(200);
        chk("s6_ignored_start_pass", 32'({done1, pass1}), 32'b11);
        chk("s6_ignored_start_cycles", 32'(busy_cyc1), 32'd96);
        chk("s6_q_empty", 32'(wq.size() + rq.size()), 32'd0);

        // Latency-3 memory, data=address.
        busy_cyc3 = 0;
        wr_cnt3 = 0;
        rd_cnt3 = 0;
        @(negedge clk);
        mode3  = 2'd1;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        begin
            int n;
            n = 0;
            while (!done3 && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk("s6_lat3_done", 32'(done3), 32'd1);
        end
        chk("s6_lat3_cycles", 32'(busy_cyc3), 32'd160);
        chk("s6_lat3_strobes", 32'({wr_cnt3[15:0], rd_cnt3[15:0]}), {16'd32, 16'd32});
        chk("s6_lat3_pass", 32'({pass3, abt3}), 32'b10);
        chk("s6_lat3_err", 32'(ecnt3), 32'd0);
        chk("s6_lat3_mem7", 32'(mem3[7]), 32'h07);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
